// File: rtl/pe_sum_accum.sv
// Five-lane psum accumulator + requantiser (bias, >>> shift, ReLU, int8 sat); build option PE_ACC_ROUND_EN.
// Latency: results register one cycle after the last beat; one window per len+2 cycles when writeback is ready.
// Backpressure: psum_ready drops from the end of the window until writeback takes sum1..sum5.
module pe_sum_accum #(
  parameter int PSUM_W = 16,
  parameter int BIAS_W = 16,
  parameter int ACC_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*PSUM_W-1:0]   psum_in,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  input  logic [5*BIAS_W-1:0]   bias_in,
  input  logic [7:0]            cfg_acc_len,
  input  logic [4:0]            cfg_shift,
  input  logic                  cfg_relu,
  output logic [7:0]            sum1,
  output logic [7:0]            sum2,
  output logic [7:0]            sum3,
  output logic [7:0]            sum4,
  output logic [7:0]            sum5,
  output logic                  sum_valid,
  input  logic                  sum_ready
);

  typedef enum logic [1:0] {IDLE, ACC, QUANT, HOLD} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc    [5];
  logic signed [ACC_W-1:0] psum_x [5];
  logic signed [ACC_W-1:0] bias_x [5];
  logic [7:0]              cnt;
  logic [7:0]              len_q;
  logic [4:0]              shift_q;
  logic                    relu_q;
  logic [7:0]              sum_q  [5];
  logic                    beat;

  assign beat = psum_valid & psum_ready;

  // Shift (arithmetic, optionally rounded), ReLU, then clamp to signed 8 bits.
  // The extra bit keeps the rounding add from wrapping near the top of the range.
  function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] a,
                                         input logic [4:0] s, input logic r);
    logic signed [ACC_W:0] w;
    logic signed [ACC_W:0] v;
    logic signed [ACC_W:0] rnd;
    int                    sh;
    sh  = int'(s);
    w   = {a[ACC_W-1], a};
    rnd = '0;
`ifdef PE_ACC_ROUND_EN
    if (s != 5'd0 && sh < ACC_W) begin
      rnd = (ACC_W+1)'(1) << (s - 5'd1);
    end
`endif
    w = w + rnd;
    if (sh >= ACC_W) v = {(ACC_W+1){a[ACC_W-1]}};
    else             v = w >>> s;
    if (r && v < 0) v = '0;
    if (v > 127)       return 8'h7F;
    else if (v < -128) return 8'h80;
    else               return v[7:0];
  endfunction

  // Sign-extend every lane to the accumulator width.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      psum_x[k] = ACC_W'($signed(psum_in[k*PSUM_W +: PSUM_W]));
      bias_x[k] = ACC_W'($signed(bias_in[k*BIAS_W +: BIAS_W]));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: window length is taken from the first beat's config (0 counts as 1).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (beat) state_nxt = (cfg_acc_len <= 8'd1) ? QUANT : ACC;
      ACC:     if (beat && (cnt + 8'd1) == len_q) state_nxt = QUANT;
      QUANT:   state_nxt = HOLD;
      HOLD:    if (sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: beats are only taken while a window is open.
  always_comb begin
    psum_ready = (state == IDLE) || (state == ACC);
  end

  // Datapath: accumulate, requantise once, hold results until writeback takes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 5; k++) begin
        acc[k]   <= '0;
        sum_q[k] <= '0;
      end
      cnt       <= '0;
      len_q     <= 8'd1;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (beat) begin
          for (int k = 0; k < 5; k++) acc[k] <= bias_x[k] + psum_x[k];
          cnt     <= 8'd1;
          len_q   <= (cfg_acc_len == 8'd0) ? 8'd1 : cfg_acc_len;
          shift_q <= cfg_shift;
          relu_q  <= cfg_relu;
        end
        ACC: if (beat) begin
          for (int k = 0; k < 5; k++) acc[k] <= acc[k] + psum_x[k];
          cnt <= cnt + 8'd1;
        end
        QUANT: begin
          for (int k = 0; k < 5; k++) sum_q[k] <= requant(acc[k], shift_q, relu_q);
          sum_valid <= 1'b1;
        end
        HOLD: if (sum_ready) sum_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign sum1 = sum_q[0];
  assign sum2 = sum_q[1];
  assign sum3 = sum_q[2];
  assign sum4 = sum_q[3];
  assign sum5 = sum_q[4];

endmodule

// File: tb/tb_pe_sum_accum.sv
// Randomised + directed bench for pe_sum_accum with a queue scoreboard.
// Reference model works on plain integers: sum, wrap, floor-divide, clamp.
// A free-running monitor pops expectations on every output handshake.
module tb_pe_sum_accum;

  typedef logic [79:0] vec_t;

  logic        clk = 1'b0;
  logic        rst;
  vec_t        psum_in;
  logic        psum_valid;
  logic        psum_ready;
  vec_t        bias_in;
  logic [7:0]  cfg_acc_len;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic [7:0]  sum1, sum2, sum3, sum4, sum5;
  logic        sum_valid;
  logic        sum_ready;

  int          total = 0;
  int          bad = 0;
  int          rdy_mode = 2;
  logic [39:0] exp_q [$];
  vec_t        beats [$];

  pe_sum_accum dut (
    .clk(clk), .rst(rst), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .bias_in(bias_in), .cfg_acc_len(cfg_acc_len),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .sum1(sum1), .sum2(sum2),
    .sum3(sum3), .sum4(sum4), .sum5(sum5), .sum_valid(sum_valid),
    .sum_ready(sum_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d, input int e);
    return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic longint lane(input vec_t v, input int k);
    logic signed [15:0] x;
    x = v[k*16 +: 16];
    return longint'(x);
  endfunction

  // Reference: wrap to 24-bit two's complement, divide by 2^s rounding toward -inf
  // (optionally half-up), ReLU, clamp to int8.
  function automatic logic [7:0] model_q(input longint a, input int s, input bit rl);
    longint w, d, v;
    w = a & 64'hFFFFFF;
    if (w >= 64'h800000) w = w - 64'h1000000;
    if (s >= 24) begin
      v = (w < 0) ? -1 : 0;
    end else begin
      d = longint'(1) << s;
`ifdef PE_ACC_ROUND_EN
      if (s > 0) w = w + d / 2;
`endif
      v = w / d;
      if (w < 0 && (w % d) != 0) v = v - 1;
    end
    if (rl && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  // Present one beat and wait (bounded) for it to be accepted; leaves time just after a posedge.
  task automatic drive_beat(input vec_t p, input vec_t b, input logic [7:0] len,
                            input logic [4:0] sh, input logic rl);
    bit took;
    int cyc;
    psum_valid = 1'b1; psum_in = p; bias_in = b;
    cfg_acc_len = len; cfg_shift = sh; cfg_relu = rl;
    cyc = 0;
    do begin
      @(negedge clk); took = psum_ready;
      @(posedge clk); #1; cyc++;
    end while (!took && cyc < 300);
    psum_valid = 1'b0;
    psum_in = vec_t'({$urandom, $urandom, $urandom});
    if (!took) chk("beat_timeout", 0, 1);
  endtask

  // Push the expected result, stream the window in `beats`, then check QUANT timing.
  task automatic send_window(input logic [7:0] len, input logic [4:0] sh, input logic rl,
                             input vec_t bias, input bit gaps);
    logic [39:0] e;
    longint      a;
    bit          seen;
    int          n;
    n = (len == 0) ? 1 : int'(len);
    for (int k = 0; k < 5; k++) begin
      a = lane(bias, k);
      for (int b = 0; b < n; b++) a += lane(beats[b], k);
      e[k*8 +: 8] = model_q(a, int'(sh), rl);
    end
    exp_q.push_back(e);
    for (int b = 0; b < n; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
      if (gaps) #1;
      if (b == 0) drive_beat(beats[b], bias, len, sh, rl);
      else drive_beat(beats[b], vec_t'({$urandom, $urandom, $urandom}), 8'($urandom),
                      5'($urandom), 1'($urandom));
    end
    @(negedge clk);
    chk("valid_early", sum_valid, 0);
    chk("quant_ready", psum_ready, 0);
    seen = 0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clk); seen = sum_valid;
    end
    chk("latency", seen, 1);
    @(posedge clk); #1;
    beats.delete();
  endtask

  // Writeback ready driver.
  initial begin
    sum_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       sum_ready = ($urandom_range(0, 3) != 0);
        1:       sum_ready = 1'b0;
        default: sum_ready = 1'b1;
      endcase
    end
  end

  // Monitor: stability and psum_ready=0 while holding, scoreboard pop on handshake.
  initial begin
    logic [39:0] prev, cur;
    bit          stall;
    stall = 0; prev = '0;
    forever begin
      @(negedge clk);
      cur = {sum5, sum4, sum3, sum2, sum1};
      if (rst && sum_valid) begin
        chk("hold_ready", psum_ready, 0);
        if (stall) chk("hold_stable", cur, prev);
        if (sum_ready) begin
          if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
          else chk("sums", cur, exp_q.pop_front());
        end
        stall = !sum_ready;
        prev = cur;
      end else begin
        stall = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bias;
    int   len;
    rst = 1'b0; psum_valid = 1'b0; psum_in = '0; bias_in = '0;
    cfg_acc_len = '0; cfg_shift = '0; cfg_relu = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_sums", {sum5, sum4, sum3, sum2, sum1}, 0);
    chk("rst_valid", sum_valid, 0);
    chk("rst_ready", psum_ready, 1);
    @(posedge clk); #1;

    // Basic accumulation, saturation / ReLU, shift, bias with len=0.
    rdy_mode = 2;
    beats.push_back(mk(10, 0, 0, 0, 0)); beats.push_back(mk(20, 0, 0, 0, 0));
    beats.push_back(mk(30, 0, 0, 0, 0));
    send_window(3, 0, 0, '0, 0);
    beats.push_back(mk(500, -500, -5, 0, 0)); send_window(1, 0, 0, '0, 0);
    beats.push_back(mk(500, -500, -5, 0, 0)); send_window(1, 0, 1, '0, 0);
    beats.push_back(mk(6, -6, 7, -7, 1));     send_window(1, 2, 0, '0, 0);
    beats.push_back(mk(0, 0, 0, 0, 10));      send_window(0, 0, 0, mk(0, 0, 0, 0, -3), 0);
    beats.push_back(mk(-32768, 32767, -1, 1, 100)); send_window(1, 31, 0, '0, 0);

    // Backpressure: writeback stalls while the next window is already waiting.
    rdy_mode = 1;
    beats.push_back(mk(1, 2, 3, 4, 5)); send_window(1, 0, 0, mk(7, 7, 7, 7, 7), 0);
    fork
      begin
        repeat (8) @(posedge clk);
        rdy_mode = 2;
      end
      begin
        beats.push_back(mk(-9, 8, -7, 6, -5)); beats.push_back(mk(1, 1, 1, 1, 1));
        send_window(2, 1, 0, '0, 0);
      end
    join
    repeat (4) @(posedge clk); #1;

    // Reset in the middle of a len=4 window: nothing may come out.
    beats.push_back(mk(50, 50, 50, 50, 50)); send_window(1, 0, 0, '0, 0);
    repeat (3) @(posedge clk); #1;
    drive_beat(mk(40, 40, 40, 40, 40), '0, 8'd4, 5'd0, 1'b0);
    drive_beat(mk(40, 40, 40, 40, 40), '0, 8'd4, 5'd0, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_sums", {sum5, sum4, sum3, sum2, sum1}, 0);
    chk("midrst_valid", sum_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("postrst_ready", psum_ready, 1);
    repeat (6) @(posedge clk); #1;
    beats.push_back(mk(3, -3, 100, -100, 0)); send_window(1, 0, 0, mk(1, 1, 1, 1, 1), 0);

    // Random windows with random writeback stalls and mid-window config noise.
    rdy_mode = 0;
    for (int w = 0; w < 40; w++) begin
      len = (w % 10 == 9) ? 20 : $urandom_range(0, 6);
      for (int b = 0; b < ((len == 0) ? 1 : len); b++) begin
        if ($urandom_range(0, 1) != 0)
          beats.push_back(vec_t'({$urandom, $urandom, $urandom}));
        else
          beats.push_back(mk($urandom_range(0, 600) - 300, $urandom_range(0, 600) - 300,
                             $urandom_range(0, 600) - 300, $urandom_range(0, 600) - 300,
                             $urandom_range(0, 600) - 300));
      end
      bias = vec_t'({$urandom, $urandom, $urandom});
      send_window(8'(len),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 10)),
                  1'($urandom), bias, 1);
    end

    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
